// File: rtl/icache_responder.sv
`default_nettype none
// icache_responder: direct-mapped instruction cache with one 32-bit word per line.
// Lookups hit with zero latency; misses fetch one word over a stall-style RAM port.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dp_imemREN,
  input  logic [31:0] dp_imemaddr,
  output logic        dp_ihit,
  output logic [31:0] dp_imemload,
  output logic        ram_iREN,
  output logic [31:0] ram_iaddr,
  input  logic        ram_iwait,
  input  logic [31:0] ram_iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [29:0]      miss_addr;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             miss;
  logic             fill;
  logic             unused_addr_bits;

  assign req_idx          = dp_imemaddr[IDX_W+1:2];
  assign req_tag          = dp_imemaddr[31:IDX_W+2];
  assign fill_idx         = miss_addr[IDX_W-1:0];
  assign fill_tag         = miss_addr[29:IDX_W];
  assign unused_addr_bits = ^dp_imemaddr[1:0];

  // A fill completes whenever data returns, even if the datapath has already
  // dropped its request; an abort only happens while memory is still busy.
  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    miss      = 1'b0;
    fill      = 1'b0;
    ram_iREN  = 1'b0;
    case (state)
      IDLE: begin
        hit  = dp_imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
        miss = dp_imemREN && !hit;
        if (miss) state_nxt = FETCH;
      end
      FETCH: begin
        if (!ram_iwait) begin
          ram_iREN  = 1'b1;
          fill      = 1'b1;
          state_nxt = IDLE;
        end else if (!dp_imemREN) begin
          state_nxt = IDLE;
        end else begin
          ram_iREN = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dp_ihit     = hit;
  assign dp_imemload = hit ? data[req_idx] : 32'd0;
  assign ram_iaddr   = {miss_addr, 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (hit) hit_count <= hit_count + 32'd1;
      if (miss) begin
        miss_count <= miss_count + 32'd1;
        miss_addr  <= dp_imemaddr[31:2];
      end
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= ram_iload;
    end
  end

endmodule
`default_nettype wire
